receive_ascii_as_binary: RTL and testbench

- Receive-side counterpart of the binary-to-ASCII transmit path.
- Drains characters from the UART receiver's buffer and assembles a line of ASCII '0'/'1' characters into an N-bit binary word.
- Sits between the uart_rx buffer and the perceptron weight/input loading logic. Lets the host push operands as text lines of the form "0101...\r\n".
- Characters arrive MSB first, matching the transmit path.

---
 rtl/receive_ascii_as_binary_pkg.sv | 15 +
 rtl/receive_ascii_as_binary.sv | 80 ++++++++
 tb/tb_receive_ascii_as_binary.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/receive_ascii_as_binary_pkg.sv
// receive_ascii_as_binary_pkg: ASCII constants shared by the transmit and receive paths, plus FSM encodings and the character classifier.
package receive_ascii_as_binary_pkg;
   localparam logic [7:0] ASCII_ZERO    = 8'd48;
   localparam logic [7:0] ASCII_ONE     = 8'd49;
   localparam logic [7:0] ASCII_NEWLINE = 8'd10;
   localparam logic [7:0] ASCII_CAR_RET = 8'd13;
   typedef enum logic {FETCH, SETTLE} phase_t;
   typedef enum logic {COLLECT, DISCARD} mode_t;
   typedef enum logic [1:0] {CH_DIGIT, CH_CR, CH_LF, CH_OTHER} char_class_t;
   function automatic char_class_t classify(input logic [7:0] c);
      return (c == ASCII_ZERO || c == ASCII_ONE) ? CH_DIGIT :
             (c == ASCII_CAR_RET) ? CH_CR :
             (c == ASCII_NEWLINE) ? CH_LF : CH_OTHER;
   endfunction
endpackage

// File: rtl/receive_ascii_as_binary.sv
// receive_ascii_as_binary: drains the UART RX buffer and assembles a line of ASCII '0'/'1' digits (MSB first) into an N-bit word.
module receive_ascii_as_binary
   import receive_ascii_as_binary_pkg::*;
#(
   parameter int N = 48
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   rx_data,
   input  logic         rx_data_present,
   output logic         read_buffer,
   output logic [N-1:0] binary_out,
   output logic         valid,
   output logic         error
);
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] FULL = CW'(N);
   phase_t phase, phase_n;
   mode_t mode, mode_n;
   char_class_t cls;
   logic [N-1:0] shift_reg, shift_n, word_n;
   logic [CW-1:0] cnt, cnt_n;
   logic valid_n, error_n;
   always_comb begin
      read_buffer = phase == FETCH && rx_data_present && !reset;
      cls = classify(rx_data);
      phase_n = FETCH;
      mode_n = mode;
      shift_n = shift_reg;
      cnt_n = cnt;
      word_n = binary_out;
      valid_n = 1'b0;
      error_n = 1'b0;
      if (read_buffer) begin
         phase_n = SETTLE;
         if (mode == DISCARD) begin
            if (cls == CH_LF) begin
               mode_n = COLLECT;
               cnt_n = '0;
            end
         end else if (cls == CH_DIGIT) begin
            // '0' and '1' differ only in bit 0
            if (cnt == FULL) begin
               error_n = 1'b1;
               mode_n = DISCARD;
            end else begin
               shift_n = {shift_reg[N-2:0], rx_data[0]};
               cnt_n = cnt + 1'b1;
            end
         end else if (cls == CH_LF) begin
            cnt_n = '0;
            valid_n = cnt == FULL;
            error_n = cnt != '0 && cnt != FULL;
            word_n = valid_n ? shift_reg : binary_out;
         end else if (cls == CH_OTHER) begin
            error_n = 1'b1;
            mode_n = DISCARD;
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= FETCH;
         mode <= COLLECT;
         shift_reg <= '0;
         cnt <= '0;
         binary_out <= '0;
         valid <= 1'b0;
         error <= 1'b0;
      end else begin
         phase <= phase_n;
         mode <= mode_n;
         shift_reg <= shift_n;
         cnt <= cnt_n;
         binary_out <= word_n;
         valid <= valid_n;
         error <= error_n;
      end
   end
endmodule

// File: tb/tb_receive_ascii_as_binary.sv
// tb_receive_ascii_as_binary: directed line-level tests against an RX buffer model, for N=8 and N=48 instances.
module tb_receive_ascii_as_binary;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic present = 1'b0;
   logic sel = 1'b0;
   logic toggle = 1'b0;
   logic present8, present48, rb8, rb48, valid8, valid48, error8, error48, read;
   logic [7:0] bin8;
   logic [47:0] bin48;
   logic [7:0] q[$];
   logic pop_pending = 1'b0;
   logic prev_rb = 1'b0;
   logic [7:0] prev_bin8 = '0;
   logic [47:0] prev_bin48 = '0;
   int cyc = 0;
   int n_reads, n_valid, n_err, n_b2b;
   int n_empty_read = 0, n_overlap = 0, n_badchg = 0;
   int vectors = 0, miscompares = 0;

   assign present8 = present && !sel;
   assign present48 = present && sel;
   assign read = sel ? rb48 : rb8;

   receive_ascii_as_binary #(.N(8)) u8 (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_present(present8),
      .read_buffer(rb8), .binary_out(bin8), .valid(valid8), .error(error8));
   receive_ascii_as_binary #(.N(48)) u48 (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_present(present48),
      .read_buffer(rb48), .binary_out(bin48), .valid(valid48), .error(error48));

   always #5 clk = ~clk;

   // read_buffer is stable from posedge+1 to the next posedge, so negedge sees what the DUT will act on
   always @(negedge clk) begin
      if (read) begin
         n_reads++;
         if (prev_rb) n_b2b++;
         pop_pending = 1'b1;
      end
      if ((rb8 && !present8) || (rb48 && !present48)) n_empty_read++;
      prev_rb = read;
      if (valid8) n_valid++;
      if (valid48) n_valid++;
      if (error8) n_err++;
      if (error48) n_err++;
      if ((valid8 && error8) || (valid48 && error48)) n_overlap++;
      if (!reset && ((bin8 !== prev_bin8 && !valid8) || (bin48 !== prev_bin48 && !valid48))) n_badchg++;
      prev_bin8 = bin8;
      prev_bin48 = bin48;
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      if (pop_pending && q.size() > 0) void'(q.pop_front());
      pop_pending = 1'b0;
      rx_data = q.size() > 0 ? q[0] : 8'h00;
      present = q.size() > 0 && !(toggle && cyc % 3 == 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic push_line(input string s, input int ending);
      for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
      if (ending == 1) q.push_back(8'd10);
      if (ending == 2) begin q.push_back(8'd13); q.push_back(8'd10); end
      if (ending == 3) begin q.push_back(8'd10); q.push_back(8'd13); end
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while ((q.size() > 0 || pop_pending) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (t >= 2000) begin
         miscompares++;
         $display("FAIL %s_drain: %0d bytes left in buffer, expected 0", tag, q.size());
      end
   endtask

   task automatic clear_counts();
      n_reads = 0;
      n_valid = 0;
      n_err = 0;
      n_b2b = 0;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (bin8 !== 8'h00) begin miscompares++; $display("FAIL reset_bin8: got %h expected 00", bin8); end
      vectors++; if (bin48 !== 48'h0) begin miscompares++; $display("FAIL reset_bin48: got %h expected 0", bin48); end
      vectors++; if ({valid8, error8, rb8} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b expected 000", {valid8, error8, rb8}); end
      @(posedge clk); #3 reset = 1'b0;
      clear_counts();
      repeat (3) @(negedge clk);
      vectors++; if (n_reads !== 0) begin miscompares++; $display("FAIL idle_reads: got %0d expected 0", n_reads); end
   endtask

   task automatic test_basic();
      clear_counts();
      push_line("10110010", 2);
      drain("basic");
      vectors++; if (n_reads !== 10) begin miscompares++; $display("FAIL basic_reads: got %0d expected 10", n_reads); end
      vectors++; if (n_b2b !== 0) begin miscompares++; $display("FAIL basic_gap: got %0d back-to-back reads expected 0", n_b2b); end
      vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL basic_valid: got %0d expected 1", n_valid); end
      vectors++; if (n_err !== 0) begin miscompares++; $display("FAIL basic_error: got %0d expected 0", n_err); end
      vectors++; if (bin8 !== 8'hB2) begin miscompares++; $display("FAIL basic_word: got %h expected b2", bin8); end
   endtask

   task automatic test_short_line();
      clear_counts();
      push_line("1111", 1);
      drain("short");
      vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL short_error: got %0d expected 1", n_err); end
      vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL short_valid: got %0d expected 0", n_valid); end
      vectors++; if (bin8 !== 8'hB2) begin miscompares++; $display("FAIL short_hold: got %h expected b2", bin8); end
      clear_counts();
      push_line("00000001", 1);
      drain("after_short");
      vectors++; if (n_valid !== 1 || n_err !== 0) begin miscompares++; $display("FAIL after_short_pulses: got valid=%0d error=%0d expected 1/0", n_valid, n_err); end
      vectors++; if (bin8 !== 8'h01) begin miscompares++; $display("FAIL after_short_word: got %h expected 01", bin8); end
   endtask

   task automatic test_overflow();
      clear_counts();
      push_line("101100101", 1);
      drain("overflow");
      vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL overflow_error: got %0d expected 1", n_err); end
      vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL overflow_valid: got %0d expected 0", n_valid); end
      vectors++; if (bin8 !== 8'h01) begin miscompares++; $display("FAIL overflow_hold: got %h expected 01", bin8); end
      clear_counts();
      push_line("11111111", 1);
      drain("after_overflow");
      vectors++; if (n_valid !== 1 || n_err !== 0) begin miscompares++; $display("FAIL after_overflow_pulses: got valid=%0d error=%0d expected 1/0", n_valid, n_err); end
      vectors++; if (bin8 !== 8'hFF) begin miscompares++; $display("FAIL after_overflow_word: got %h expected ff", bin8); end
   endtask

   task automatic test_bad_char();
      clear_counts();
      push_line("10x10010", 1);
      push_line("", 1);
      push_line("00001111", 1);
      drain("bad_char");
      vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL bad_char_error: got %0d expected 1", n_err); end
      vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL bad_char_valid: got %0d expected 1", n_valid); end
      vectors++; if (bin8 !== 8'h0F) begin miscompares++; $display("FAIL bad_char_word: got %h expected 0f", bin8); end
   endtask

   task automatic test_async_reset();
      clear_counts();
      push_line("1100", 0);
      drain("partial");
      @(posedge clk); #3 reset = 1'b1;
      #1;
      vectors++; if (bin8 !== 8'h00) begin miscompares++; $display("FAIL async_reset_bin: got %h expected 00", bin8); end
      vectors++; if ({valid8, error8, rb8} !== 3'b000) begin miscompares++; $display("FAIL async_reset_pulses: got %b expected 000", {valid8, error8, rb8}); end
      repeat (2) @(negedge clk);
      @(posedge clk); #3 reset = 1'b0;
      clear_counts();
      push_line("11000000", 1);
      drain("after_reset");
      vectors++; if (n_valid !== 1 || n_err !== 0) begin miscompares++; $display("FAIL after_reset_pulses: got valid=%0d error=%0d expected 1/0", n_valid, n_err); end
      vectors++; if (bin8 !== 8'hC0) begin miscompares++; $display("FAIL after_reset_word: got %h expected c0", bin8); end
   endtask

   task automatic test_wide(input logic [47:0] w, input string tag);
      string s = "";
      for (int i = 47; i >= 0; i--) s = {s, w[i] ? "1" : "0"};
      clear_counts();
      push_line(s, 3);
      drain(tag);
      vectors++; if (n_reads !== 50) begin miscompares++; $display("FAIL %s_reads: got %0d expected 50", tag, n_reads); end
      vectors++; if (n_valid !== 1 || n_err !== 0) begin miscompares++; $display("FAIL %s_pulses: got valid=%0d error=%0d expected 1/0", tag, n_valid, n_err); end
      vectors++; if (bin48 !== w) begin miscompares++; $display("FAIL %s_word: got %h expected %h", tag, bin48, w); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_line();
      test_overflow();
      test_bad_char();
      test_async_reset();
      sel = 1'b1;
      toggle = 1'b1;
      repeat (2) @(negedge clk);
      test_wide(48'hA5C3_0F1E_96B7, "wide_a");
      test_wide(48'h0123_4567_89AB, "wide_b");
      vectors++; if (bin8 !== 8'hC0) begin miscompares++; $display("FAIL idle_narrow_hold: got %h expected c0", bin8); end
      vectors++; if (n_empty_read !== 0) begin miscompares++; $display("FAIL empty_read: got %0d expected 0", n_empty_read); end
      vectors++; if (n_overlap !== 0) begin miscompares++; $display("FAIL valid_error_overlap: got %0d expected 0", n_overlap); end
      vectors++; if (n_badchg !== 0) begin miscompares++; $display("FAIL word_change_without_valid: got %0d expected 0", n_badchg); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
